// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory serial loader.
package imem_loader_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_DATA_HI = 3'd3,
      ST_DATA_LO = 3'd4,
      ST_CHECK   = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERROR   = 3'd7
   } loadState_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rxState_t;

   function automatic int clksPerBit(input int clkHz, input int baud);
      return clkHz / baud;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Write port of the instruction RAM: the loader drives it, the RAM consumes it.
interface imem_loader_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              mem_wren;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;

   modport master (output mem_wren, mem_addr, mem_data);
   modport slave  (input  mem_wren, mem_addr, mem_data);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start check.
module uart_rx
   import imem_loader_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err
);
   localparam int CPB   = clksPerBit(CLK_HZ, BAUD);
   localparam int CNT_W = $clog2(CPB + 1);
   localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CPB / 2 - 1);

   logic             rxMeta, rxSync, rxPrev;
   rxState_t         state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [2:0]       bitIdx, bitIdxNext;
   logic [7:0]       shiftReg, shiftNext;
   logic             validNext, errNext;

   assign byte_out = shiftReg;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         rxMeta     <= 1'b1;
         rxSync     <= 1'b1;
         rxPrev     <= 1'b1;
         state      <= RX_IDLE;
         cnt        <= '0;
         bitIdx     <= '0;
         shiftReg   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rxMeta     <= rx;
         rxSync     <= rxMeta;
         rxPrev     <= rxSync;
         state      <= stateNext;
         cnt        <= cntNext;
         bitIdx     <= bitIdxNext;
         shiftReg   <= shiftNext;
         byte_valid <= validNext;
         frame_err  <= errNext;
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      validNext  = 1'b0;
      errNext    = 1'b0;
      case (state)
         RX_IDLE: begin
            if (rxPrev && !rxSync) begin
               stateNext = RX_START;
               cntNext   = HALF_TC;
            end
         end
         RX_START: begin
            if (cnt == '0) begin
               // a line that is high again at mid-start was only a glitch
               if (!rxSync) begin
                  stateNext  = RX_DATA;
                  cntNext    = FULL_TC;
                  bitIdxNext = '0;
               end else begin
                  stateNext = RX_IDLE;
               end
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt == '0) begin
               shiftNext = {rxSync, shiftReg[7:1]};
               cntNext   = FULL_TC;
               if (bitIdx == 3'd7) stateNext = RX_STOP;
               else                bitIdxNext = bitIdx + 1'b1;
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt == '0) begin
               validNext = rxSync;
               errNext   = !rxSync;
               stateNext = RX_IDLE;
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         default: stateNext = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/imem_loader.sv
// Frame FSM that writes a UART-delivered program image into instruction RAM and
// holds the CPU in reset until a checksum-valid image is in place.
//
//   state   | meaning
//   IDLE    | nothing loaded since reset, waiting for sync
//   LEN_HI  | expecting length high byte
//   LEN_LO  | expecting length low byte, then range check
//   DATA_HI | expecting high byte of next word
//   DATA_LO | expecting low byte, write word on arrival
//   CHECK   | expecting checksum byte
//   DONE    | image accepted, CPU released, waiting for reload sync
//   ERROR   | frame rejected, CPU held, waiting for sync
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          rx,
   imem_loader_if.master memBus,
   output logic          cpu_hold,
   output logic          load_done,
   output logic          error
);
   localparam int          IDX_W   = ADDR_W + 1;
   localparam logic [15:0] MAX_LEN = 16'(2 ** ADDR_W);

   logic [7:0]        rxByte;
   logic              byteValid, frameErr;
   loadState_t        state, stateNext;
   logic [15:0]       lenReg, lenNext, lenFull;
   logic [7:0]        chkSum, chkNext, hiByte, hiNext;
   logic [IDX_W-1:0]  wordIdx, idxNext, idxInc;
   logic              wren, wrenNext, holdNext, doneNext, errNext;
   logic [ADDR_W-1:0] addr, addrNext;
   logic [DATA_W-1:0] data, dataNext;

   uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) uRx (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .rx         (rx),
      .byte_out   (rxByte),
      .byte_valid (byteValid),
      .frame_err  (frameErr)
   );

   assign memBus.mem_wren = wren;
   assign memBus.mem_addr = addr;
   assign memBus.mem_data = data;
   assign lenFull         = {lenReg[15:8], rxByte};
   assign idxInc          = wordIdx + 1'b1;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= ST_IDLE;
         lenReg    <= '0;
         chkSum    <= '0;
         hiByte    <= '0;
         wordIdx   <= '0;
         wren      <= 1'b0;
         addr      <= '0;
         data      <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= stateNext;
         lenReg    <= lenNext;
         chkSum    <= chkNext;
         hiByte    <= hiNext;
         wordIdx   <= idxNext;
         wren      <= wrenNext;
         addr      <= addrNext;
         data      <= dataNext;
         cpu_hold  <= holdNext;
         load_done <= doneNext;
         error     <= errNext;
      end
   end

   always_comb begin
      stateNext = state;
      lenNext   = lenReg;
      chkNext   = chkSum;
      hiNext    = hiByte;
      idxNext   = wordIdx;
      wrenNext  = 1'b0;
      addrNext  = addr;
      dataNext  = data;
      holdNext  = cpu_hold;
      doneNext  = 1'b0;
      errNext   = error;
      if (frameErr) begin
         if (!(state inside {ST_IDLE, ST_DONE, ST_ERROR})) begin
            stateNext = ST_ERROR;
            errNext   = 1'b1;
         end
      end else if (byteValid) begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (rxByte == SYNC_BYTE) begin
                  stateNext = ST_LEN_HI;
                  holdNext  = 1'b1;
                  errNext   = 1'b0;
                  chkNext   = '0;
                  idxNext   = '0;
               end
            end
            ST_LEN_HI: begin
               lenNext   = {rxByte, lenReg[7:0]};
               chkNext   = chkSum ^ rxByte;
               stateNext = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               lenNext = lenFull;
               chkNext = chkSum ^ rxByte;
               if (lenFull == '0 || lenFull > MAX_LEN) begin
                  stateNext = ST_ERROR;
                  errNext   = 1'b1;
               end else begin
                  stateNext = ST_DATA_HI;
               end
            end
            ST_DATA_HI: begin
               hiNext    = rxByte;
               chkNext   = chkSum ^ rxByte;
               stateNext = ST_DATA_LO;
            end
            ST_DATA_LO: begin
               wrenNext  = 1'b1;
               addrNext  = wordIdx[ADDR_W-1:0];
               dataNext  = DATA_W'({hiByte, rxByte});
               chkNext   = chkSum ^ rxByte;
               idxNext   = idxInc;
               stateNext = (16'(idxInc) == lenReg) ? ST_CHECK : ST_DATA_HI;
            end
            ST_CHECK: begin
               if (chkSum == rxByte) begin
                  stateNext = ST_DONE;
                  doneNext  = 1'b1;
                  holdNext  = 1'b0;
               end else begin
                  stateNext = ST_ERROR;
                  errNext   = 1'b1;
               end
            end
            default: stateNext = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are built at byte level, expected RAM
// writes and load outcomes come from the frame rules, and a monitor checks every write.
module tb_imem_loader;
   localparam int CLK_HZ = 1600000;
   localparam int BAUD   = 100000;
   localparam int CPB    = CLK_HZ / BAUD;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;
   logic rx       = 1'b1;
   logic cpu_hold, load_done, error;

   imem_loader_if #(.ADDR_W(12), .DATA_W(16)) memBus ();

   imem_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(12), .DATA_W(16)) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .rx        (rx),
      .memBus    (memBus),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .error     (error)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int total = 0;
   int bad = 0;
   int doneCount = 0;
   int doneExp = 0;
   logic [11:0] expAddr[$];
   logic [15:0] expData[$];
   logic [15:0] wordQ[$];
   logic [7:0]  txQ[$];
   logic [7:0]  lastChk;
   logic prevWren = 1'b0, prevDone = 1'b0, prevHold = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // write/pulse monitor
   always @(negedge CLOCK_50) begin
      if (reset) begin
         prevWren = 1'b0;
         prevDone = 1'b0;
         prevHold = 1'b1;
      end else begin
         if (memBus.mem_wren) begin
            if (expAddr.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write actual addr=0x%0h data=0x%0h required none",
                        memBus.mem_addr, memBus.mem_data);
            end else begin
               logic [11:0] a;
               logic [15:0] d;
               a = expAddr.pop_front();
               d = expData.pop_front();
               check("write_addr_data", {memBus.mem_addr, memBus.mem_data}, {a, d});
            end
            if (prevWren) check("wren_single_pulse", 32'(prevWren), 32'd0);
         end
         if (load_done) begin
            doneCount++;
            if (prevDone) check("done_single_pulse", 32'(prevDone), 32'd0);
         end
         if (prevHold && !cpu_hold) check("hold_release_with_done", 32'(load_done), 32'd1);
         prevWren = memBus.mem_wren;
         prevDone = load_done;
         prevHold = cpu_hold;
      end
   end

   initial begin
      repeat (200000) @(posedge CLOCK_50);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      @(posedge CLOCK_50); #1;
      rx = 1'b0;
      repeat (CPB) @(posedge CLOCK_50); #1;
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(posedge CLOCK_50); #1;
      end
      rx = stopBit;
      repeat (CPB) @(posedge CLOCK_50); #1;
      rx = 1'b1;
      repeat (CPB) @(posedge CLOCK_50);
   endtask

   task automatic glitch();
      @(posedge CLOCK_50); #1;
      rx = 1'b0;
      @(posedge CLOCK_50); #1;
      rx = 1'b1;
      repeat (12 * CPB) @(posedge CLOCK_50);
   endtask

   task automatic sendQ();
      foreach (txQ[i]) sendByte(txQ[i], 1'b1);
   endtask

   // frame = sync, length, words high byte first, XOR of everything after sync
   task automatic buildFrame(input logic [15:0] n, input logic [7:0] chkFlip);
      logic [7:0] c;
      c = 8'h00;
      txQ = {};
      txQ.push_back(8'hA5);
      txQ.push_back(n[15:8]);
      txQ.push_back(n[7:0]);
      foreach (wordQ[i]) begin
         txQ.push_back(wordQ[i][15:8]);
         txQ.push_back(wordQ[i][7:0]);
      end
      for (int i = 1; i < txQ.size(); i++) c = c ^ txQ[i];
      lastChk = c;
      txQ.push_back(c ^ chkFlip);
      if (n >= 16'd1 && n <= 16'd4096) begin
         foreach (wordQ[i]) begin
            expAddr.push_back(12'(i));
            expData.push_back(wordQ[i]);
         end
         if (chkFlip == 8'h00) doneExp++;
      end
   endtask

   task automatic endChecks(input string name, input logic hold, input logic err);
      repeat (4) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check({name, "_done_count"}, 32'(doneCount), 32'(doneExp));
      check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(hold));
      check({name, "_error"}, 32'(error), 32'(err));
      check({name, "_writes_pending"}, 32'(expAddr.size()), 32'd0);
   endtask

   initial begin
      repeat (5) @(posedge CLOCK_50);
      #1 reset = 1'b0;
      @(negedge CLOCK_50);
      check("reset_cpu_hold", 32'(cpu_hold), 32'd1);
      check("reset_mem_wren", 32'(memBus.mem_wren), 32'd0);
      check("reset_mem_addr", 32'(memBus.mem_addr), 32'd0);
      check("reset_mem_data", 32'(memBus.mem_data), 32'd0);
      check("reset_load_done", 32'(load_done), 32'd0);
      check("reset_error", 32'(error), 32'd0);

      glitch();
      endChecks("idle_glitch", 1'b1, 1'b0);

      // good two-word frame
      wordQ = {16'h1234, 16'hABCD};
      buildFrame(16'd2, 8'h00);
      check("model_chk_literal", 32'(lastChk), 32'h42);
      check("model_len_bytes", 32'(txQ.size()), 32'd8);
      sendQ();
      endChecks("frameA", 1'b0, 1'b0);
      check("frameA_addr_held", 32'(memBus.mem_addr), 32'd1);
      check("frameA_data_held", 32'(memBus.mem_data), 32'hABCD);

      // same frame, checksum 0x43
      buildFrame(16'd2, 8'h01);
      sendQ();
      endChecks("bad_chk", 1'b1, 1'b1);

      // recovery, including 0xA5 bytes as data
      wordQ = {16'hA5A5, 16'h0001, 16'hFFFF};
      buildFrame(16'd3, 8'h00);
      sendQ();
      endChecks("recover", 1'b0, 1'b0);
      check("recover_data_held", 32'(memBus.mem_data), 32'hFFFF);

      // N = 0
      txQ = {8'hA5, 8'h00, 8'h00};
      sendQ();
      @(negedge CLOCK_50);
      check("n0_error", 32'(error), 32'd1);
      endChecks("n0", 1'b1, 1'b1);

      // sync clears error, then N = 4097
      sendByte(8'hA5, 1'b1);
      @(negedge CLOCK_50);
      check("sync_clears_error", 32'(error), 32'd0);
      sendByte(8'h10, 1'b1);
      sendByte(8'h01, 1'b1);
      @(negedge CLOCK_50);
      check("n4097_error", 32'(error), 32'd1);
      endChecks("n4097", 1'b1, 1'b1);

      // framing error during DATA_HI, trailing bytes must be ignored
      txQ = {8'hA5, 8'h00, 8'h02};
      sendQ();
      sendByte(8'h55, 1'b0);
      @(negedge CLOCK_50);
      check("frame_err_error", 32'(error), 32'd1);
      txQ = {8'h66, 8'h77, 8'h88, 8'h99};
      sendQ();
      endChecks("frame_err", 1'b1, 1'b1);

      // glitch between bytes of an active frame must not insert a byte
      wordQ = {16'h5A0F};
      buildFrame(16'd1, 8'h00);
      for (int i = 0; i < 3; i++) sendByte(txQ[i], 1'b1);
      glitch();
      for (int i = 3; i < txQ.size(); i++) sendByte(txQ[i], 1'b1);
      endChecks("mid_glitch", 1'b0, 1'b0);

      // reload from DONE, aborted by reset after one word
      sendByte(8'hA5, 1'b1);
      @(negedge CLOCK_50);
      check("reload_hold", 32'(cpu_hold), 32'd1);
      expAddr.push_back(12'h000);
      expData.push_back(16'h1122);
      txQ = {8'h00, 8'h02, 8'h11, 8'h22};
      sendQ();
      @(posedge CLOCK_50); #1;
      reset = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1 reset = 1'b0;
      @(negedge CLOCK_50);
      check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
      check("abort_error", 32'(error), 32'd0);
      check("abort_mem_addr", 32'(memBus.mem_addr), 32'd0);
      wordQ = {16'hBEEF, 16'hCAFE};
      buildFrame(16'd2, 8'h00);
      sendQ();
      endChecks("after_reset", 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
